// File: rtl/cdr_tx_pattern_gen.sv
// rtl/cdr_tx_pattern_gen.sv - CDR transmit test source: NCO symbol timing, framed preamble/PRBS7 payload
// and a first-order edge filter on the signed line samples.
module cdr_tx_pattern_gen #(
  parameter int                    PHASE_BITS   = 32,
  parameter logic [PHASE_BITS-1:0] FCW_NOM      = 32'h8000_0000,
  parameter logic signed [7:0]     AMP          = 8'sd64,
  parameter int                    ALPHA_SHIFT  = 1,
  parameter int                    PREAMBLE_LEN = 32,
  parameter int                    TAIL_LEN     = 8,
  parameter logic [6:0]            PRBS_SEED    = 7'h7F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic signed [31:0] fcw_ofs,
  input  logic [15:0]        payload_len,
  output logic               sym_strobe,
  output logic               tx_bit,
  output logic signed [7:0]  y_n,
  output logic               busy,
  output logic [1:0]         state,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PRE  = 2'b01,
    S_PAY  = 2'b10,
    S_TAIL = 2'b11
  } state_t;

  localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] TAIL_LAST = 16'(TAIL_LEN - 1);
  localparam logic        SEED_BIT  = PRBS_SEED[6] ^ PRBS_SEED[5];

  logic [PHASE_BITS-1:0] phase_q, phase_d, eff;
  logic                  wrap;
  state_t                state_q, state_d;
  logic [15:0]           sym_cnt_q, sym_cnt_d;
  logic [15:0]           plen_q, plen_d;
  logic                  start_pend_q, start_pend_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [6:0]            prbs_q, prbs_d;
  logic                  prbs_bit;
  logic                  tx_bit_q, tx_bit_d;
  logic signed [7:0]     y_q, y_d;
  logic signed [7:0]     target;
  logic signed [8:0]     diff, step;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  to_tail;

  always_comb begin
    eff      = FCW_NOM + PHASE_BITS'(fcw_ofs);
    phase_d  = phase_q + eff;
    wrap     = phase_d < phase_q;
    strobe_d = wrap;

    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    plen_d    = plen_q;
    prbs_d    = prbs_q;
    tx_bit_d  = tx_bit_q;
    done_d    = 1'b0;
    to_tail   = 1'b0;
    prbs_bit  = prbs_q[6] ^ prbs_q[5];

    // A start coincident with stop wins; stop is then dropped.
    start_pend_d = start_pend_q | (start && state_q == S_IDLE);
    stop_pend_d  = stop_pend_q | (stop && !start && (state_q == S_PRE || state_q == S_PAY));

    if (wrap) begin
      case (state_q)
        S_IDLE: begin
          if (start_pend_d) begin
            state_d      = S_PRE;
            sym_cnt_d    = 16'd0;
            tx_bit_d     = 1'b1;
            start_pend_d = 1'b0;
          end
        end
        S_PRE: begin
          if (stop_pend_q) begin
            to_tail = 1'b1;
          end else if (sym_cnt_q == PRE_LAST) begin
            state_d   = S_PAY;
            sym_cnt_d = 16'd0;
            plen_d    = payload_len;
            tx_bit_d  = SEED_BIT;
            prbs_d    = {PRBS_SEED[5:0], SEED_BIT};
          end else begin
            tx_bit_d  = ~tx_bit_q;
            sym_cnt_d = sym_cnt_q + 16'd1;
          end
        end
        S_PAY: begin
          if (stop_pend_q || (plen_q != 16'd0 && sym_cnt_q == plen_q - 16'd1)) begin
            to_tail = 1'b1;
          end else begin
            tx_bit_d  = prbs_bit;
            prbs_d    = {prbs_q[5:0], prbs_bit};
            sym_cnt_d = sym_cnt_q + 16'd1;
          end
        end
        S_TAIL: begin
          if (sym_cnt_q == TAIL_LAST) begin
            state_d   = S_IDLE;
            sym_cnt_d = 16'd0;
            tx_bit_d  = 1'b0;
            done_d    = 1'b1;
          end else begin
            sym_cnt_d = sym_cnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (to_tail) begin
      state_d     = S_TAIL;
      sym_cnt_d   = 16'd0;
      tx_bit_d    = 1'b0;
      stop_pend_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);

    // Edge filter runs every clk on the currently registered symbol level.
    if (state_q == S_PRE || state_q == S_PAY) begin
      target = tx_bit_q ? AMP : -AMP;
    end else begin
      target = 8'sd0;
    end
    diff = $signed({target[7], target}) - $signed({y_q[7], y_q});
    step = diff >>> ALPHA_SHIFT;
    y_d  = y_q + step[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      state_q      <= S_IDLE;
      sym_cnt_q    <= 16'd0;
      plen_q       <= 16'd0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      prbs_q       <= PRBS_SEED;
      tx_bit_q     <= 1'b0;
      y_q          <= 8'sd0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      plen_q       <= plen_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      prbs_q       <= prbs_d;
      tx_bit_q     <= tx_bit_d;
      y_q          <= y_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign sym_strobe = strobe_q;
  assign tx_bit     = tx_bit_q;
  assign y_n        = y_q;
  assign busy       = busy_q;
  assign state      = state_q;
  assign done       = done_q;

endmodule

// File: tb/tb_cdr_tx_pattern_gen.sv
// tb/tb_cdr_tx_pattern_gen.sv - bench for cdr_tx_pattern_gen against a symbol-queue reference model
// covering two filter settings side by side.
module tb_cdr_tx_pattern_gen;

  localparam int PL = 4;
  localparam int TL = 2;

  logic               clk = 1'b0;
  logic               rst_n, start, stop;
  logic signed [31:0] fcw_ofs;
  logic [15:0]        payload_len;

  logic               s0_strobe, s0_bit, s0_busy, s0_done;
  logic signed [7:0]  s0_y;
  logic [1:0]         s0_state;
  logic               s1_strobe, s1_bit, s1_busy, s1_done;
  logic signed [7:0]  s1_y;
  logic [1:0]         s1_state;

  cdr_tx_pattern_gen #(.ALPHA_SHIFT(0), .PREAMBLE_LEN(PL), .TAIL_LEN(TL)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fcw_ofs(fcw_ofs),
    .payload_len(payload_len), .sym_strobe(s0_strobe), .tx_bit(s0_bit), .y_n(s0_y),
    .busy(s0_busy), .state(s0_state), .done(s0_done));

  cdr_tx_pattern_gen #(.ALPHA_SHIFT(1), .PREAMBLE_LEN(PL), .TAIL_LEN(TL)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fcw_ofs(fcw_ofs),
    .payload_len(payload_len), .sym_strobe(s1_strobe), .tx_bit(s1_bit), .y_n(s1_y),
    .busy(s1_busy), .state(s1_state), .done(s1_done));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a precomputed list of (state, bit) symbols consumed one per NCO carry.
  longint m_phase;
  int     m_state, m_bit, m_y0, m_y1, m_strobe, m_done;
  bit     m_start_pend, m_stop_pend;
  int     q_st[$];
  int     q_bit[$];

  task automatic model_reset();
    m_phase = 0; m_state = 0; m_bit = 0; m_y0 = 0; m_y1 = 0;
    m_strobe = 0; m_done = 0; m_start_pend = 0; m_stop_pend = 0;
    q_st.delete(); q_bit.delete();
  endtask

  task automatic push_tail();
    for (int i = 0; i < TL; i++) begin q_st.push_back(3); q_bit.push_back(0); end
  endtask

  task automatic build_frame();
    int b[$];
    int n;
    q_st.delete(); q_bit.delete();
    for (int i = 0; i < PL; i++) begin q_st.push_back(1); q_bit.push_back((i % 2 == 0) ? 1 : 0); end
    n = (payload_len == 16'd0) ? 300 : int'(payload_len);
    for (int i = 0; i < 7; i++) b.push_back(1);
    for (int i = 0; i < n; i++) begin
      b.push_back(b[i] ^ b[i+1]);
      q_st.push_back(2); q_bit.push_back(b[i+7]);
    end
    push_tail();
  endtask

  task automatic model_edge(input bit st_in, input bit sp_in);
    int     tgt, old_state;
    longint eff, sum;
    bit     wrap, stop_latch, start_latch, took, entered_tail;
    tgt = (m_state == 1 || m_state == 2) ? (m_bit ? 64 : -64) : 0;
    m_y0 = tgt;
    m_y1 = m_y1 + ((tgt - m_y1) >>> 1);
    stop_latch  = sp_in && !st_in && (m_state == 1 || m_state == 2);
    start_latch = st_in && m_state == 0;
    eff  = (longint'(32'h8000_0000) + longint'(fcw_ofs)) & 64'hFFFF_FFFF;
    sum  = m_phase + eff;
    wrap = sum >= 64'h1_0000_0000;
    m_phase = sum & 64'hFFFF_FFFF;
    m_done = 0; took = 0; entered_tail = 0;
    old_state = m_state;
    if (wrap) begin
      if (m_state == 0) begin
        if (m_start_pend || start_latch) begin
          build_frame();
          m_state = q_st.pop_front(); m_bit = q_bit.pop_front();
          took = 1;
        end
      end else if (m_state != 3 && m_stop_pend) begin
        q_st.delete(); q_bit.delete(); push_tail();
        m_state = q_st.pop_front(); m_bit = q_bit.pop_front();
      end else if (q_st.size() == 0) begin
        m_state = 0; m_bit = 0; m_done = 1;
      end else begin
        m_state = q_st.pop_front(); m_bit = q_bit.pop_front();
      end
      entered_tail = (m_state == 3 && old_state != 3);
    end
    m_strobe = wrap;
    m_start_pend = took ? 1'b0 : (m_start_pend | start_latch);
    m_stop_pend  = entered_tail ? 1'b0 : (m_stop_pend | stop_latch);
  endtask

  task automatic compare_all();
    check_eq("strobe0", longint'(s0_strobe), m_strobe);
    check_eq("strobe1", longint'(s1_strobe), m_strobe);
    check_eq("bit0", longint'(s0_bit), m_bit);
    check_eq("bit1", longint'(s1_bit), m_bit);
    check_eq("state0", longint'(s0_state), m_state);
    check_eq("state1", longint'(s1_state), m_state);
    check_eq("busy0", longint'(s0_busy), longint'(m_state != 0));
    check_eq("busy1", longint'(s1_busy), longint'(m_state != 0));
    check_eq("done0", longint'(s0_done), m_done);
    check_eq("done1", longint'(s1_done), m_done);
    check_eq("y0", longint'(s0_y), m_y0);
    check_eq("y1", longint'(s1_y), m_y1);
  endtask

  task automatic step();
    bit st_in, sp_in, rs;
    st_in = start; sp_in = stop; rs = rst_n;
    @(posedge clk);
    if (!rs) model_reset();
    else model_edge(st_in, sp_in);
    #1;
    compare_all();
  endtask

  int rec_bits[$];
  int rec_pay[$];
  int done_cnt, tail_cnt, strobe_cnt;

  task automatic step_rec();
    step();
    if (s0_strobe && s0_busy) rec_bits.push_back(int'(s0_bit));
    if (s0_strobe && s0_state == 2'b10) rec_pay.push_back(int'(s0_bit));
    if (s0_strobe && s0_state == 2'b11) tail_cnt++;
    if (s0_strobe) strobe_cnt++;
    if (s0_done) done_cnt++;
  endtask

  task automatic run_to_done(input string tag, input int limit);
    int c;
    c = 0;
    done_cnt = 0;
    while (done_cnt == 0 && c < limit) begin step_rec(); c++; end
    check_eq(tag, longint'(done_cnt), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; step_rec(); start = 1'b0;
  endtask

  int exp_frame[13] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int exp_head[7]   = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; fcw_ofs = '0; payload_len = 16'd7;
    model_reset();
    #2;
    compare_all();
    step(); step();
    rst_n = 1'b1;

    // Nominal rate: one symbol every 2 clk.
    strobe_cnt = 0;
    for (int i = 0; i < 20; i++) step_rec();
    check_eq("strobe_rate_nom", strobe_cnt, 10);

    // Short frame with known bit sequence.
    rec_bits.delete();
    payload_len = 16'd7;
    pulse_start();
    run_to_done("frame_done", 200);
    check_eq("frame_len", rec_bits.size(), 13);
    for (int i = 0; i < 13 && i < rec_bits.size(); i++) check_eq("frame_bit", rec_bits[i], exp_frame[i]);
    check_eq("frame_idle_state", longint'(s0_state), 0);
    check_eq("frame_idle_busy", longint'(s0_busy), 0);

    // Infinite payload: PRBS7 period, then stop and an ignored start in TAIL.
    rec_pay.delete();
    payload_len = 16'd0;
    pulse_start();
    c = 0;
    while (rec_pay.size() < 254 && c < 1000) begin step_rec(); c++; end
    check_eq("prbs_count", rec_pay.size(), 254);
    for (int i = 0; i < 7 && i < rec_pay.size(); i++) check_eq("prbs_head", rec_pay[i], exp_head[i]);
    for (int i = 0; i < 127 && i + 127 < rec_pay.size(); i++) check_eq("prbs_period", rec_pay[i+127], rec_pay[i]);
    tail_cnt = 0;
    stop = 1'b1; step_rec(); stop = 1'b0;
    c = 0;
    while (s0_state != 2'b11 && c < 20) begin step_rec(); c++; end
    check_eq("stop_to_tail", longint'(s0_state), 3);
    pulse_start();
    run_to_done("stop_done", 100);
    check_eq("tail_syms", tail_cnt, TL);
    for (int i = 0; i < 10; i++) step_rec();
    check_eq("tail_start_ignored", longint'(s0_busy), 0);

    // Slow NCO: one symbol every 4 clk, exercising the filter settle.
    fcw_ofs = -32'sh4000_0000;
    payload_len = 16'd5;
    pulse_start();
    strobe_cnt = 0;
    for (int i = 0; i < 40; i++) step_rec();
    check_eq("strobe_rate_slow", strobe_cnt, 10);
    run_to_done("slow_done", 400);

    // Asynchronous reset mid-payload.
    fcw_ofs = '0;
    payload_len = 16'd50;
    pulse_start();
    c = 0;
    while (s0_state != 2'b10 && c < 50) begin step_rec(); c++; end
    check_eq("reach_payload", longint'(s0_state), 2);
    step_rec(); step_rec();
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_state", longint'(s0_state), 0);
    check_eq("arst_y0", longint'(s0_y), 0);
    check_eq("arst_y1", longint'(s1_y), 0);
    check_eq("arst_busy", longint'(s0_busy), 0);
    check_eq("arst_bit", longint'(s0_bit), 0);
    check_eq("arst_done", longint'(s0_done), 0);
    model_reset();
    done_cnt = 0;
    step(); step(); step();
    rst_n = 1'b1;
    rec_bits.delete();
    pulse_start();
    c = 0;
    while (rec_bits.size() == 0 && c < 20) begin step_rec(); c++; end
    check_eq("post_reset_first_bit", rec_bits.size() > 0 ? rec_bits[0] : -1, 1);
    run_to_done("post_reset_done", 500);

    // Randomized start/stop/rate traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: fcw_ofs = '0;
          1: fcw_ofs = -32'sh4000_0000;
          2: fcw_ofs = 32'sh2000_0000;
          default: fcw_ofs = $signed($urandom_range(0, 32'h3FFF_FFFF)) - 32'sh2000_0000;
        endcase
      end
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      if (start && m_state == 0 && !m_start_pend) payload_len = 16'($urandom_range(1, 20));
      step_rec();
      start = 1'b0;
      stop  = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
